lab5cpu_mem_arbiter: RTL and testbench
======================================

LAB5CPU_MEM_ARBITER -- requirements
Module: lab5cpu_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: word address width.
REQ-002 SHALL have parameter DATA_W, default 32: data width.
REQ-003 SHALL have parameter BE_W, default 4: byteenable width, DATA_W/8.
REQ-004 SHALL have port clk, input, 1: single clock; every register is in this domain.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports m0_read, m0_write, input, 1 each: master 0 (CPU data) command strobes.
REQ-007 SHALL have ports m0_address (ADDR_W), m0_byteenable (BE_W), m0_writedata (DATA_W), input: master 0 command fields.
REQ-008 SHALL have ports m0_waitrequest (1), m0_readdatavalid (1), m0_readdata (DATA_W), output: master 0 responses.
REQ-009 SHALL have ports m1_* for master 1 (transmit DMA), identical to REQ-006..008.
REQ-010 SHALL have ports mem_chipselect, mem_write, mem_clken, output, 1 each: memory controls.
REQ-011 SHALL have ports mem_address (ADDR_W), mem_byteenable (BE_W), mem_writedata (DATA_W), output: memory command fields.
REQ-012 SHALL have port mem_readdata, input, DATA_W: memory read data, valid one cycle after the address edge.

Function
REQ-013 SHALL treat a master as requesting when read or write is high; read and write both high SHALL be handled as a write.
REQ-014 SHALL grant at most one master per cycle, combinationally from the current requests and the last_grant register.
REQ-015 SHALL use round-robin on contention: grant the master not in last_grant; with one requester, grant it.
REQ-016 SHALL update last_grant on every cycle with a grant; it SHALL hold when there is no grant.
REQ-017 SHALL drive mem_address, mem_byteenable, mem_writedata and mem_write from the granted master, and assert mem_chipselect only with a grant.
REQ-018 SHALL force mem_byteenable to all ones for reads.
REQ-019 SHALL assert mN_waitrequest when master N requests without a grant; it SHALL deassert in the grant cycle and stay low when master N is idle.
REQ-020 SHALL require a stalled master to hold its command; commands are not latched.
REQ-021 SHALL register rd_pending and rd_owner on each granted read; in the next cycle the owner's readdatavalid is high and its readdata equals mem_readdata.
REQ-022 SHALL keep readdatavalid low for the non-owner, and for both masters after a write.
REQ-023 SHALL be fully pipelined: back-to-back granted reads give readdatavalid on consecutive cycles, and a write may follow a read with no gap.
REQ-024 SHALL hold mem_clken at 1.
REQ-025 SHALL keep a 2-state FSM, IDLE and BUSY: IDLE to BUSY on any grant; BUSY to IDLE when there is no grant and rd_pending is 0.
REQ-026 SHALL provide a 16-bit saturating wait counter per master, counting cycles with waitrequest high and clearing on grant; it is exposed to verification via hierarchy only.

Reset
REQ-027 SHALL, while reset is high, hold last_grant = master 1 (so master 0 wins first), rd_pending = 0, FSM = IDLE and wait counters = 0.
REQ-028 SHALL, while reset is high, drive both readdatavalid low, both waitrequest high and mem_chipselect/mem_write low.
REQ-029 SHALL drop any read in flight when reset asserts mid-read; no readdatavalid for it after release.

Structure
REQ-030 SHALL put the master-index constants, FSM state encoding and the default ADDR_W, DATA_W and BE_W in shared package lab5cpu_mem_pkg.
REQ-031 SHALL implement the grant logic as sub-module lab5cpu_rr_arb2; the response steering and FSM stay at top level.

Verification
REQ-032 SHALL cover: m0 read at 0x010 alone, memory word 0xDEADBEEF -> m0_waitrequest 0, m0_readdatavalid in the next cycle, m0_readdata = 0xDEADBEEF, m1 sees no valid.
REQ-033 SHALL cover: m0 and m1 both read every cycle for 6 cycles after reset -> grants m0, m1, m0, m1, m0, m1; each master stalled on alternate cycles.
REQ-034 SHALL cover: m1 write to 0x7FF with byteenable 0x3 and data 0x12345678 over 0xFFFFFFFF, then m0 read 0x7FF -> 0xFFFF5678.
REQ-035 SHALL cover: m0 reads 0x000, 0x001, 0x002 back-to-back -> readdatavalid on three consecutive cycles with data in order.
REQ-036 SHALL cover: reset asserted in the cycle after a granted m1 read -> no m1_readdatavalid during or after reset; first grant after release goes to m0.
REQ-037 SHALL cover: m1 held stalled for 70000 cycles by forced contention -> wait counter saturates at 0xFFFF, then clears on grant.

Source files
------------

// File: rtl/lab5cpu_mem_pkg.sv
// Shared constants for the lab5cpu memory arbiter: default widths, master indices
// and FSM state encoding.
package lab5cpu_mem_pkg;

  localparam int unsigned DefaultAddrW = 11;
  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultBeW   = DefaultDataW / 8;
  localparam int unsigned WaitCntW     = 16;

  localparam logic Master0 = 1'b0;
  localparam logic Master1 = 1'b1;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/lab5cpu_rr_arb2.sv
// Two-input round-robin grant: purely combinational from the current requests
// and the master granted most recently.
module lab5cpu_rr_arb2
  import lab5cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = Master0;
    case (req)
      2'b01:   gnt_idx = Master0;
      2'b10:   gnt_idx = Master1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = Master0;
    endcase
  end

endmodule

// File: rtl/lab5cpu_mem_arbiter.sv
// Arbitrates the CPU data port (m0) and the transmit DMA (m1) onto one synchronous
// on-chip memory; read data returns one cycle after the granted address.
module lab5cpu_mem_arbiter
  import lab5cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned BE_W   = DefaultBeW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic              m0_readdatavalid,
  output logic [DATA_W-1:0] m0_readdata,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic              m1_readdatavalid,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic req0, req1;
  logic gnt_valid, gnt_idx, gnt_ok, gnt0, gnt1;
  logic sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  logic last_grant_q;
  logic rd_pending_q, rd_owner_q;
  arb_state_e state_q, state_d;
  logic [WaitCntW-1:0] wait_cnt0_q, wait_cnt0_d, wait_cnt1_q, wait_cnt1_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  lab5cpu_rr_arb2 u_arb (
    .req        ({req1, req0}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // Reset masks the grant so both masters see waitrequest and the memory stays idle.
  assign gnt_ok = gnt_valid & ~reset;
  assign gnt0   = gnt_ok & (gnt_idx == Master0);
  assign gnt1   = gnt_ok & (gnt_idx == Master1);

  always_comb begin
    if (gnt_idx == Master1) begin
      sel_write = m1_write;
      sel_addr  = m1_address;
      sel_be    = m1_byteenable;
      sel_wdata = m1_writedata;
    end else begin
      sel_write = m0_write;
      sel_addr  = m0_address;
      sel_be    = m0_byteenable;
      sel_wdata = m0_writedata;
    end
  end

  assign mem_chipselect = gnt_ok;
  assign mem_write      = gnt_ok & sel_write;
  assign mem_clken      = 1'b1;
  assign mem_address    = sel_addr;
  assign mem_byteenable = sel_write ? sel_be : {BE_W{1'b1}};
  assign mem_writedata  = sel_wdata;

  assign m0_waitrequest = reset | (req0 & ~gnt0);
  assign m1_waitrequest = reset | (req1 & ~gnt1);

  assign m0_readdatavalid = rd_pending_q & (rd_owner_q == Master0);
  assign m1_readdatavalid = rd_pending_q & (rd_owner_q == Master1);
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (gnt_ok) state_d = StBusy;
      StBusy: if (!gnt_ok && !rd_pending_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Saturating stall counters, cleared in the cycle after a grant.
  always_comb begin
    wait_cnt0_d = wait_cnt0_q;
    wait_cnt1_d = wait_cnt1_q;
    if (gnt0) begin
      wait_cnt0_d = '0;
    end else if (m0_waitrequest && (wait_cnt0_q != {WaitCntW{1'b1}})) begin
      wait_cnt0_d = wait_cnt0_q + 1'b1;
    end
    if (gnt1) begin
      wait_cnt1_d = '0;
    end else if (m1_waitrequest && (wait_cnt1_q != {WaitCntW{1'b1}})) begin
      wait_cnt1_d = wait_cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= Master1;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= Master0;
      state_q      <= StIdle;
      wait_cnt0_q  <= '0;
      wait_cnt1_q  <= '0;
    end else begin
      if (gnt_ok) last_grant_q <= gnt_idx;
      rd_pending_q <= gnt_ok & ~sel_write;
      if (gnt_ok && !sel_write) rd_owner_q <= gnt_idx;
      state_q     <= state_d;
      wait_cnt0_q <= wait_cnt0_d;
      wait_cnt1_q <= wait_cnt1_d;
    end
  end

endmodule

// File: tb/tb_lab5cpu_mem_arbiter.sv
// Self-checking bench for lab5cpu_mem_arbiter: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_lab5cpu_mem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int BW = 4;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct packed {
    cmd_t          c0;
    cmd_t          c1;
    logic          ew0;
    logic          ew1;
    logic          ecs;
    logic          ewr;
    logic [AW-1:0] eaddr;
    logic          erv0;
    logic          erv1;
  } row_t;

  logic clk = 1'b0;
  logic reset;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata;
  logic m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata, mem_readdata;
  logic mem_chipselect, mem_write, mem_clken;

  lab5cpu_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdatavalid(m0_readdatavalid),
    .m0_readdata(m0_readdata),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdatavalid(m1_readdatavalid),
    .m1_readdata(m1_readdata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a);
    if (a == 16) return 32'hDEAD_BEEF;
    if (a == 2047) return 32'hFFFF_FFFF;
    return 32'h5A00_0000 ^ (a * 32'h0001_0203);
  endfunction

  // Synchronous memory seen by the DUT, loaded with the pattern on the first edge.
  logic [DW-1:0] mem [2048];
  logic mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else if (mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem[mem_address];
      end
    end
  end

  // Reference model state: transaction-level view of grants and memory contents.
  logic [DW-1:0] ref_mem [2048];
  int last_m, pend_owner, gnt;
  bit pend;
  logic [DW-1:0] pend_data;
  int n_checks = 0;
  int n_errors = 0;

  logic s_w0, s_w1, s_rv0, s_rv1, s_cs, s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_rd0, s_rd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [AW-1:0] addr,
                              input logic [BW-1:0] be, input logic [DW-1:0] data);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = addr; c.be = be; c.data = data;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    int kind;
    kind = int'($urandom_range(0, 3));
    return mk(kind == 1 || kind == 3, kind >= 2, AW'($urandom_range(0, 31)),
              BW'($urandom_range(0, 15)), $urandom);
  endfunction

  task automatic ref_write(input cmd_t c);
    for (int b = 0; b < BW; b++)
      if (c.be[b]) ref_mem[c.addr][8*b +: 8] = c.data[8*b +: 8];
  endtask

  task automatic drive(input cmd_t c0, input cmd_t c1);
    m0_read = c0.rd; m0_write = c0.wr; m0_address = c0.addr;
    m0_byteenable = c0.be; m0_writedata = c0.data;
    m1_read = c1.rd; m1_write = c1.wr; m1_address = c1.addr;
    m1_byteenable = c1.be; m1_writedata = c1.data;
  endtask

  // One clock cycle: drive commands, predict from the model, compare, advance model.
  task automatic do_cycle(input cmd_t c0, input cmd_t c1);
    bit r0, r1;
    int g;
    cmd_t c;
    drive(c0, c1);
    r0 = c0.rd | c0.wr;
    r1 = c1.rd | c1.wr;
    if (r0 && r1) g = (last_m == 0) ? 1 : 0;
    else if (r0) g = 0;
    else if (r1) g = 1;
    else g = -1;
    @(negedge clk);
    s_w0 = m0_waitrequest; s_w1 = m1_waitrequest; s_rv0 = m0_readdatavalid;
    s_rv1 = m1_readdatavalid; s_cs = mem_chipselect; s_wr = mem_write;
    s_addr = mem_address; s_rd0 = m0_readdata; s_rd1 = m1_readdata;
    chk("m0_waitrequest", 32'(m0_waitrequest), 32'(r0 && g != 0));
    chk("m1_waitrequest", 32'(m1_waitrequest), 32'(r1 && g != 1));
    chk("mem_chipselect", 32'(mem_chipselect), 32'(g >= 0));
    chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(pend && pend_owner == 0));
    chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(pend && pend_owner == 1));
    if (pend && pend_owner == 0) chk("m0_readdata", m0_readdata, pend_data);
    if (pend && pend_owner == 1) chk("m1_readdata", m1_readdata, pend_data);
    pend = 0;
    if (g >= 0) begin
      c = (g == 0) ? c0 : c1;
      chk("mem_write", 32'(mem_write), 32'(c.wr));
      chk("mem_address", 32'(mem_address), 32'(c.addr));
      chk("mem_byteenable", 32'(mem_byteenable), c.wr ? 32'(c.be) : 32'hF);
      if (c.wr) begin
        chk("mem_writedata", mem_writedata, c.data);
        ref_write(c);
      end else begin
        pend = 1;
        pend_owner = g;
        pend_data = ref_mem[c.addr];
      end
      last_m = g;
    end else begin
      chk("mem_write idle", 32'(mem_write), 32'h0);
    end
    gnt = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(mk(1, 0, 11'h001, 4'h0, 0), mk(1, 1, 11'h002, 4'hF, 0));
    @(negedge clk);
    chk("rst m0_waitrequest", 32'(m0_waitrequest), 32'h1);
    chk("rst m1_waitrequest", 32'(m1_waitrequest), 32'h1);
    chk("rst m0_readdatavalid", 32'(m0_readdatavalid), 32'h0);
    chk("rst m1_readdatavalid", 32'(m1_readdatavalid), 32'h0);
    chk("rst mem_chipselect", 32'(mem_chipselect), 32'h0);
    chk("rst mem_write", 32'(mem_write), 32'h0);
    chk("rst mem_clken", 32'(mem_clken), 32'h1);
    chk("rst last_grant", 32'(dut.last_grant_q), 32'h1);
    chk("rst rd_pending", 32'(dut.rd_pending_q), 32'h0);
    chk("rst state", 32'(dut.state_q), 32'h0);
    chk("rst wait_cnt0", 32'(dut.wait_cnt0_q), 32'h0);
    chk("rst wait_cnt1", 32'(dut.wait_cnt1_q), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
    last_m = 1;
    pend = 0;
  endtask

  row_t vec [12];

  initial begin
    cmd_t i_c, r0_c, r1_c, w0_c, w1_c, rw0_c, cur0, cur1;
    bit seen;
    for (int i = 0; i < 2048; i++) ref_mem[i] = pat(i);
    i_c   = mk(0, 0, 11'h000, 4'h0, 32'h0);
    r0_c  = mk(1, 0, 11'h100, 4'h0, 32'h0);
    r1_c  = mk(1, 0, 11'h200, 4'h0, 32'h0);
    w0_c  = mk(0, 1, 11'h100, 4'hF, 32'hC0C0_C0C0);
    w1_c  = mk(0, 1, 11'h200, 4'hF, 32'hA1A1_A1A1);
    rw0_c = mk(1, 1, 11'h100, 4'hF, 32'hB0B0_B0B0);
    //           c0     c1    ew0   ew1   ecs   ewr   eaddr    erv0  erv1
    vec[0]  = '{r0_c,  r1_c, 1'b0, 1'b1, 1'b1, 1'b0, 11'h100, 1'b0, 1'b0};
    vec[1]  = '{r0_c,  r1_c, 1'b1, 1'b0, 1'b1, 1'b0, 11'h200, 1'b1, 1'b0};
    vec[2]  = '{r0_c,  r1_c, 1'b0, 1'b1, 1'b1, 1'b0, 11'h100, 1'b0, 1'b1};
    vec[3]  = '{r0_c,  r1_c, 1'b1, 1'b0, 1'b1, 1'b0, 11'h200, 1'b1, 1'b0};
    vec[4]  = '{r0_c,  r1_c, 1'b0, 1'b1, 1'b1, 1'b0, 11'h100, 1'b0, 1'b1};
    vec[5]  = '{r0_c,  r1_c, 1'b1, 1'b0, 1'b1, 1'b0, 11'h200, 1'b1, 1'b0};
    vec[6]  = '{i_c,   i_c,  1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b1};
    vec[7]  = '{i_c,   w1_c, 1'b0, 1'b0, 1'b1, 1'b1, 11'h200, 1'b0, 1'b0};
    vec[8]  = '{rw0_c, i_c,  1'b0, 1'b0, 1'b1, 1'b1, 11'h100, 1'b0, 1'b0};
    vec[9]  = '{w0_c,  w1_c, 1'b1, 1'b0, 1'b1, 1'b1, 11'h200, 1'b0, 1'b0};
    vec[10] = '{r0_c,  r1_c, 1'b0, 1'b1, 1'b1, 1'b0, 11'h100, 1'b0, 1'b0};
    vec[11] = '{i_c,   i_c,  1'b0, 1'b0, 1'b0, 1'b0, 11'h000, 1'b1, 1'b0};

    reset = 1'b1;
    drive(i_c, i_c);
    do_reset();

    // Vector table, starting straight out of reset so m0 wins first.
    for (int i = 0; i < 12; i++) begin
      do_cycle(vec[i].c0, vec[i].c1);
      chk($sformatf("vec%0d wait0", i), 32'(s_w0), 32'(vec[i].ew0));
      chk($sformatf("vec%0d wait1", i), 32'(s_w1), 32'(vec[i].ew1));
      chk($sformatf("vec%0d cs", i), 32'(s_cs), 32'(vec[i].ecs));
      chk($sformatf("vec%0d wr", i), 32'(s_wr), 32'(vec[i].ewr));
      if (vec[i].ecs) chk($sformatf("vec%0d addr", i), 32'(s_addr), 32'(vec[i].eaddr));
      chk($sformatf("vec%0d rv0", i), 32'(s_rv0), 32'(vec[i].erv0));
      chk($sformatf("vec%0d rv1", i), 32'(s_rv1), 32'(vec[i].erv1));
    end

    // Lone m0 read of a known word.
    do_cycle(mk(1, 0, 11'h010, 4'h0, 0), i_c);
    chk("rd010 wait0", 32'(s_w0), 32'h0);
    do_cycle(i_c, i_c);
    chk("rd010 rv0", 32'(s_rv0), 32'h1);
    chk("rd010 data", s_rd0, 32'hDEAD_BEEF);
    chk("rd010 rv1", 32'(s_rv1), 32'h0);

    // Partial write from m1, read back by m0.
    do_cycle(i_c, mk(0, 1, 11'h7FF, 4'h3, 32'h1234_5678));
    do_cycle(mk(1, 0, 11'h7FF, 4'h0, 0), i_c);
    do_cycle(i_c, i_c);
    chk("be write readback", s_rd0, 32'hFFFF_5678);

    // Back-to-back reads: data on consecutive cycles, in order.
    for (int i = 0; i < 4; i++) begin
      do_cycle((i < 3) ? mk(1, 0, AW'(i), 4'h0, 0) : i_c, i_c);
      if (i > 0) begin
        chk($sformatf("b2b rv0 %0d", i), 32'(s_rv0), 32'h1);
        chk($sformatf("b2b data %0d", i), s_rd0, pat(i - 1));
      end
    end

    // Reset asserted in the cycle after a granted m1 read.
    do_cycle(i_c, mk(1, 0, 11'h005, 4'h0, 0));
    reset = 1'b1;
    drive(i_c, i_c);
    pend = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst mid-read rv1", 32'(m1_readdatavalid), 32'h0);
      chk("rst mid-read wait1", 32'(m1_waitrequest), 32'h1);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    last_m = 1;
    do_cycle(i_c, i_c);
    chk("post-rst rv1", 32'(s_rv1), 32'h0);
    do_cycle(r0_c, r1_c);
    chk("post-rst first grant m0", 32'(s_w0), 32'h0);
    chk("post-rst m1 stalled", 32'(s_w1), 32'h1);
    do_cycle(i_c, i_c);

    // Randomized traffic; stalled masters hold their command until granted.
    cur0 = rand_cmd();
    cur1 = rand_cmd();
    for (int n = 0; n < 400; n++) begin
      do_cycle(cur0, cur1);
      if (gnt == 0 || !(cur0.rd || cur0.wr)) cur0 = rand_cmd();
      if (gnt == 1 || !(cur1.rd || cur1.wr)) cur1 = rand_cmd();
    end
    do_cycle(i_c, i_c);

    // Long forced stall of m1: wait counter saturates, then clears on grant.
    do_reset();
    drive(mk(1, 0, 11'h003, 4'h0, 0), mk(1, 0, 11'h004, 4'h0, 0));
    force dut.last_grant_q = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat wait_cnt1", 32'(dut.wait_cnt1_q), 32'hFFFF);
    chk("sat wait1", 32'(m1_waitrequest), 32'h1);
    chk("sat wait_cnt0", 32'(dut.wait_cnt0_q), 32'h0);
    release dut.last_grant_q;
    seen = 0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (!m1_waitrequest) seen = 1;
    end
    chk("m1 granted after stall", 32'(seen), 32'h1);
    if (seen) begin
      @(negedge clk);
      chk("wait_cnt1 cleared", 32'(dut.wait_cnt1_q), 32'h0);
    end
    drive(i_c, i_c);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
             n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
